// File: rtl/tick_bcd_counter_if.sv
// Bus between the prescaler-side driver and tick_bcd_counter: slow clock input,
// count controls, and the tick/bcd/carry results.
interface tick_bcd_counter_if #(
  parameter int DIGITS = 2
);
  logic                  clk_scaled;
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  tick;
  logic [4*DIGITS-1:0]   bcd;
  logic                  carry;

  modport master (
    output clk_scaled, en, up, load, load_val,
    input  tick, bcd, carry
  );

  modport slave (
    input  clk_scaled, en, up, load, load_val,
    output tick, bcd, carry
  );
endinterface

// File: rtl/tick_bcd_counter.sv
// Synchronises clk_scaled, turns its rising edges into one-cycle ticks and counts
// them in BCD. Define TICK_BCD_DOWN_EN to compile in the down-count/borrow path.
module tick_bcd_counter #(
  parameter int DIGITS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  tick_bcd_counter_if.slave  bus
);
  localparam int         W         = 4 * DIGITS;
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   armed_q;
  logic [2:0]             warm_cnt;
  logic                   tick_q;
  logic [W-1:0]           bcd_q;
  logic                   carry_q;

  logic [W-1:0]           inc_val;
  logic                   inc_wrap;
  logic [W-1:0]           load_clamped;
  logic [W-1:0]           next_val;
  logic                   next_wrap;

  // armed holds off edge detection until the chain and prev reflect the real
  // input level, so a high clk_scaled at reset release never fakes an edge.
  // NOTE: registered state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
      warm_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.clk_scaled};
      prev_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~prev_q & armed_q;
      if (!armed_q) begin
        if (warm_cnt == WARM_LAST) armed_q  <= 1'b1;
        else                       warm_cnt <= warm_cnt + 3'd1;
      end
    end
  end

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    logic c;
    c       = 1'b1;
    inc_val = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    inc_wrap = c;
  end

  always_comb begin
    load_clamped = bus.load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
  end

`ifdef TICK_BCD_DOWN_EN
  logic [W-1:0] dec_val;
  logic         dec_wrap;

  always_comb begin
    logic b;
    b       = 1'b1;
    dec_val = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    dec_wrap = b;
  end

  always_comb begin
    next_val  = bus.up ? inc_val  : dec_val;
    next_wrap = bus.up ? inc_wrap : dec_wrap;
  end
`else
  logic unused_up;
  assign unused_up = bus.up;

  always_comb begin
    next_val  = inc_val;
    next_wrap = inc_wrap;
  end
`endif

  // Load wins over a coincident tick, which is then simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q   <= '0;
      carry_q <= 1'b0;
    end else if (bus.load) begin
      bcd_q   <= load_clamped;
      carry_q <= 1'b0;
    end else if (tick_q && bus.en) begin
      bcd_q   <= next_val;
      carry_q <= next_wrap;
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign bus.tick  = tick_q;
  assign bus.bcd   = bcd_q;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_tick_bcd_counter.sv
// Self-checking bench for tick_bcd_counter (DIGITS=2, SYNC_STAGES=2): vector table
// plus hand-written warm-up, latency, load/tick priority and async reset sequences.
module tb_tick_bcd_counter;
  localparam int DIGITS = 2;
  localparam int SYNC   = 2;

  typedef struct {
    logic [7:0] load_val;
    logic       en;
    logic       up;
    logic [7:0] exp_bcd;
    logic       exp_carry;
  } vec_t;

  typedef struct {
    logic [7:0] bcd;
    logic       carry;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_bcd_counter_if #(.DIGITS(DIGITS)) bus ();

  tick_bcd_counter #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  n_vectors   = 0;
  int  n_miss      = 0;
  int  pushed      = 0;
  int  tick_count  = 0;
  int  carry_cycles = 0;
  int  exp_carries = 0;
  sb_t exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] clamp8(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] > 4'd9) r[3:0] = 4'd9;
    if (v[7:4] > 4'd9) r[7:4] = 4'd9;
    return r;
  endfunction

  task automatic expect_tick(input logic [7:0] b, input logic c);
    sb_t item;
    item.bcd   = b;
    item.carry = c;
    exp_q.push_back(item);
    pushed++;
  endtask

  // Scoreboard monitor: the count update lands one cycle after tick is seen.
  logic prev_tick = 1'b0;
  always @(negedge clk) begin
    sb_t item;
    if (rst) begin
      prev_tick = 1'b0;
    end else begin
      if (bus.carry) carry_cycles++;
      if (prev_tick) begin
        check("tick_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          item = exp_q.pop_front();
          check("tick_bcd", 32'(bus.bcd), 32'(item.bcd));
          check("tick_carry", 32'(bus.carry), 32'(item.carry));
        end
      end
      if (bus.tick) tick_count++;
      prev_tick = bus.tick;
    end
  end

  task automatic pulse();
    @(negedge clk);
    #4 bus.clk_scaled = 1'b1;
    repeat (4) @(negedge clk);
    #4 bus.clk_scaled = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus.load     = 1'b1;
    bus.load_val = v;
    @(negedge clk);
    bus.load = 1'b0;
    check("load_bcd", 32'(bus.bcd), 32'(clamp8(v)));
    check("load_carry", 32'(bus.carry), 0);
  endtask

  initial begin
    int ticks_before;

    vecs[0] = '{8'h09, 1'b1, 1'b1, 8'h10, 1'b0};
    vecs[1] = '{8'h99, 1'b1, 1'b1, 8'h00, 1'b1};
`ifdef TICK_BCD_DOWN_EN
    vecs[2] = '{8'h10, 1'b1, 1'b0, 8'h09, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h99, 1'b1};
`else
    vecs[2] = '{8'h10, 1'b1, 1'b0, 8'h11, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
`endif
    vecs[4] = '{8'h3F, 1'b1, 1'b1, 8'h40, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, 1'b1, 8'h96, 1'b0};
    vecs[6] = '{8'h19, 1'b0, 1'b1, 8'h19, 1'b0};
    vecs[7] = '{8'h98, 1'b1, 1'b1, 8'h99, 1'b0};

    bus.clk_scaled = 1'b1;
    bus.en         = 1'b1;
    bus.up         = 1'b1;
    bus.load       = 1'b0;
    bus.load_val   = 8'h00;

    // Warm-up with clk_scaled already high: no tick may appear.
    repeat (3) @(negedge clk);
    check("reset_bcd", 32'(bus.bcd), 0);
    check("reset_tick", 32'(bus.tick), 0);
    check("reset_carry", 32'(bus.carry), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("warmup_tick", 32'(bus.tick), 0);
    end
    check("warmup_bcd", 32'(bus.bcd), 0);
    check("warmup_carry", 32'(bus.carry), 0);
    bus.clk_scaled = 1'b0;
    repeat (4) @(negedge clk);

    // Tick latency: rise 1 ns before edge k.
    expect_tick(8'h01, 1'b0);
    @(negedge clk);
    #4 bus.clk_scaled = 1'b1;
    @(negedge clk); check("lat_k_tick", 32'(bus.tick), 0);
    @(negedge clk); check("lat_k1_tick", 32'(bus.tick), 0);
    @(negedge clk); check("lat_k2_tick", 32'(bus.tick), 1);
                    check("lat_k2_bcd", 32'(bus.bcd), 0);
    @(negedge clk); check("lat_k3_tick", 32'(bus.tick), 0);
                    check("lat_k3_bcd", 32'(bus.bcd), 8'h01);
    #4 bus.clk_scaled = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].load_val);
      bus.en = vecs[i].en;
      bus.up = vecs[i].up;
      expect_tick(vecs[i].exp_bcd, vecs[i].exp_carry);
      if (vecs[i].exp_carry) exp_carries++;
      pulse();
      bus.en = 1'b1;
      bus.up = 1'b1;
    end

    // Load coinciding with tick: load wins, tick dropped.
    do_load(8'h00);
    @(negedge clk);
    #4 bus.clk_scaled = 1'b1;
    repeat (3) @(negedge clk);
    check("coincide_tick", 32'(bus.tick), 1);
    bus.load     = 1'b1;
    bus.load_val = 8'h3F;
    expect_tick(8'h39, 1'b0);
    @(negedge clk);
    bus.load = 1'b0;
    #4 bus.clk_scaled = 1'b0;
    repeat (4) @(negedge clk);

    // Enable low: ticks still come, count holds.
    do_load(8'h25);
    bus.en = 1'b0;
    ticks_before = tick_count;
    for (int i = 0; i < 3; i++) begin
      expect_tick(8'h25, 1'b0);
      pulse();
    end
    check("en0_ticks", 32'(tick_count - ticks_before), 3);
    check("en0_bcd", 32'(bus.bcd), 8'h25);
    bus.en = 1'b1;

    // Async reset mid-operation with an edge in flight.
    do_load(8'h47);
    @(negedge clk);
    #4 bus.clk_scaled = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bcd", 32'(bus.bcd), 0);
    check("async_rst_tick", 32'(bus.tick), 0);
    check("async_rst_carry", 32'(bus.carry), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_bcd", 32'(bus.bcd), 0);
    bus.clk_scaled = 1'b0;
    repeat (4) @(negedge clk);
    expect_tick(8'h01, 1'b0);
    pulse();
    check("post_rst_count", 32'(bus.bcd), 8'h01);

    check("queue_empty", 32'(exp_q.size()), 0);
    check("tick_count", 32'(tick_count), 32'(pushed));
    check("carry_cycles", 32'(carry_cycles), 32'(exp_carries));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
    $finish;
  end
endmodule
